// File: rtl/cpu32_regs_pkg.sv
// rtl/cpu32_regs_pkg.sv - register-file address constants shared by the register file and its write arbiter
package cpu32_regs_pkg;

  localparam int ADDRSIZE = 5;
  localparam int ST_ADDR  = 28;
  localparam int LR_ADDR  = 29;
  localparam int SP_ADDR  = 30;
  localparam int PC_ADDR  = 31;

  typedef logic [ADDRSIZE-1:0] reg_addr_t;

endpackage

// File: rtl/regwr_arbiter_rr_pick.sv
// rtl/regwr_arbiter_rr_pick.sv - round-robin first-set finder: scans mask from start, wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   start,
  output logic            found,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = PW'((int'(start) + k) % NREQ);
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - grants up to two register-file write ports per cycle to NREQ requesters, round-robin
// Port 1 never receives port 0's address, so the register file never resolves same-address writes.
module regwr_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDRSIZE = cpu32_regs_pkg::ADDRSIZE,
  parameter int ST_ADDR  = cpu32_regs_pkg::ST_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDRSIZE-1:0] req_wa,
  input  logic [NREQ*32-1:0]       req_wd,
  input  logic                     st_lock,
  output logic [NREQ-1:0]          ack,
  output logic [1:0]               write,
  output logic [ADDRSIZE-1:0]      wa0,
  output logic [ADDRSIZE-1:0]      wa1,
  output logic [31:0]              wd0,
  output logic [31:0]              wd1
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDRSIZE-1:0] wa_arr [NREQ];
  logic [31:0]         wd_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign wa_arr[g] = req_wa[g*ADDRSIZE +: ADDRSIZE];
    assign wd_arr[g] = req_wd[g*32 +: 32];
  end

  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [1:0]          write_q, write_d;
  logic [ADDRSIZE-1:0] wa0_q, wa0_d, wa1_q, wa1_d;
  logic [31:0]         wd0_q, wd0_d, wd1_q, wd1_d;

  logic [NREQ-1:0] elig, mask1;
  logic            f0, f1;
  logic [PW-1:0]   i0, i1, start1;

  // A requester acked last cycle has not yet withdrawn its request, so it is held out for one cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && !ack_q[i] && !(st_lock && (wa_arr[i] == ADDRSIZE'(ST_ADDR)));
    end
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick0 (
    .mask  (elig),
    .start (ptr_q),
    .found (f0),
    .idx   (i0)
  );

  always_comb begin
    mask1  = '0;
    start1 = PW'((int'(i0) + 1) % NREQ);
    for (int i = 0; i < NREQ; i++) begin
      mask1[i] = elig[i] && (PW'(i) != i0) && (wa_arr[i] != wa_arr[i0]);
    end
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick1 (
    .mask  (mask1),
    .start (start1),
    .found (f1),
    .idx   (i1)
  );

  always_comb begin
    ptr_d   = ptr_q;
    ack_d   = '0;
    write_d = '0;
    wa0_d   = '0;
    wa1_d   = '0;
    wd0_d   = '0;
    wd1_d   = '0;
    if (f0) begin
      ack_d[i0]  = 1'b1;
      write_d[0] = 1'b1;
      wa0_d      = wa_arr[i0];
      wd0_d      = wd_arr[i0];
      ptr_d      = PW'((int'(i0) + 1) % NREQ);
      if (f1) begin
        ack_d[i1]  = 1'b1;
        write_d[1] = 1'b1;
        wa1_d      = wa_arr[i1];
        wd1_d      = wd_arr[i1];
        ptr_d      = PW'((int'(i1) + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      ack_q   <= '0;
      write_q <= '0;
      wa0_q   <= '0;
      wa1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      write_q <= write_d;
      wa0_q   <= wa0_d;
      wa1_q   <= wa1_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
    end
  end

  assign ack   = ack_q;
  assign write = write_q;
  assign wa0   = wa0_q;
  assign wa1   = wa1_q;
  assign wd0   = wd0_q;
  assign wd1   = wd1_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - directed scoreboard bench for regwr_arbiter
module tb_regwr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_wa;
  logic [NREQ*32-1:0] req_wd;
  logic            st_lock;
  logic [NREQ-1:0] ack;
  logic [1:0]      write;
  logic [AW-1:0]   wa0, wa1;
  logic [31:0]     wd0, wd1;

  regwr_arbiter #(.NREQ(NREQ), .ADDRSIZE(AW), .ST_ADDR(28)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_wa  (req_wa),
    .req_wd  (req_wd),
    .st_lock (st_lock),
    .ack     (ack),
    .write   (write),
    .wa0     (wa0),
    .wa1     (wa1),
    .wd0     (wd0),
    .wd1     (wd1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [1:0]      write;
    logic [AW-1:0]   wa0;
    logic [31:0]     wd0;
    logic [AW-1:0]   wa1;
    logic [31:0]     wd1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] D0 = 32'hAAAA0001;
  localparam logic [31:0] D1 = 32'hBBBB0002;
  localparam logic [31:0] D2 = 32'hCCCC0003;
  localparam logic [31:0] D3 = 32'hDDDD0004;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_wa(input int a0, input int a1, input int a2, input int a3);
    req_wa = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Drive this cycle's inputs, queue the expected next-cycle outputs, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic [3:0] rq, input logic lk,
                      input logic [3:0] e_ack, input logic [1:0] e_wr,
                      input int e_wa0, input logic [31:0] e_wd0,
                      input int e_wa1, input logic [31:0] e_wd1);
    exp_t e;
    rst     = r;
    req     = rq;
    st_lock = lk;
    e.ack = e_ack; e.write = e_wr;
    e.wa0 = AW'(e_wa0); e.wd0 = e_wd0;
    e.wa1 = AW'(e_wa1); e.wd1 = e_wd1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".ack"},   32'(ack),   32'(e.ack));
    chk({tag, ".write"}, 32'(write), 32'(e.write));
    chk({tag, ".wa0"},   32'(wa0),   32'(e.wa0));
    chk({tag, ".wd0"},   wd0,        e.wd0);
    chk({tag, ".wa1"},   32'(wa1),   32'(e.wa1));
    chk({tag, ".wd1"},   wd1,        e.wd1);
  endtask

  initial begin
    rst = 1'b1; req = '0; st_lock = 1'b0;
    req_wd = {D3, D2, D1, D0};
    set_wa(5, 0, 0, 0);
    @(posedge clk); #1;

    step("reset",      1, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);
    step("single",     0, 4'b0001, 0, 4'b0001, 2'b01, 5, D0, 0, 0);
    step("idle0",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);
    set_wa(6, 8, 0, 0);
    step("ptr1",       0, 4'b0011, 0, 4'b0011, 2'b11, 8, D1, 6, D0);
    step("rst_a",      1, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);

    set_wa(1, 2, 3, 4);
    step("four_a",     0, 4'b1111, 0, 4'b0011, 2'b11, 1, D0, 2, D1);
    step("four_b",     0, 4'b1111, 0, 4'b1100, 2'b11, 3, D2, 4, D3);
    step("idle1",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);

    set_wa(7, 7, 0, 0);
    step("same_a",     0, 4'b0011, 0, 4'b0001, 2'b01, 7, D0, 0, 0);
    step("same_b",     0, 4'b0011, 0, 4'b0010, 2'b01, 7, D1, 0, 0);
    step("idle2",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);

    set_wa(28, 0, 9, 0);
    step("lock_a",     0, 4'b0101, 1, 4'b0100, 2'b01, 9, D2, 0, 0);
    step("lock_b",     0, 4'b0101, 0, 4'b0001, 2'b01, 28, D0, 0, 0);
    step("idle3",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);

    set_wa(12, 0, 15, 11);
    step("to_ptr3",    0, 4'b0100, 0, 4'b0100, 2'b01, 15, D2, 0, 0);
    step("wrap",       0, 4'b1001, 0, 4'b1001, 2'b11, 11, D3, 12, D0);
    step("idle4",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);
    set_wa(6, 8, 0, 0);
    step("wrap_ptr1",  0, 4'b0011, 0, 4'b0011, 2'b11, 8, D1, 6, D0);
    step("idle5",      0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0, 0, 0);

    set_wa(1, 2, 3, 4);
    step("pre_rst",    0, 4'b1111, 0, 4'b0110, 2'b11, 2, D1, 3, D2);
    step("mid_rst",    1, 4'b1111, 0, 4'b0000, 2'b00, 0, 0, 0, 0);
    step("post_rst",   0, 4'b1111, 0, 4'b0011, 2'b11, 1, D0, 2, D1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
